// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared FSM/special-case types and the NAN/INF result encodings.
`ifndef FP_DEFS_VH
`define FP_DEFS_VH
`define NAN {1'b0, {EXP_W{1'b1}}, 1'b1, {(DATA_W-EXP_W-2){1'b0}}}
`define INF(s) {s, {EXP_W{1'b1}}, {(DATA_W-EXP_W-1){1'b0}}}
`endif
package fp_mul_pkg;
  typedef enum logic [1:0] {IDLE, MUL, NORM, RND} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} spec_e;
  function automatic spec_e classify(input logic az, ai, an, bz, bi, bn);
    return (an | bn | (ai & bz) | (bi & az)) ? SP_NAN :
           (ai | bi) ? SP_INF : (az | bz) ? SP_ZERO : SP_NONE;
  endfunction
endpackage

// File: rtl/fp_special.sv
// fp_special: classifies one operand magnitude as zero (exponent 0), infinity or NaN.
module fp_special #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-2:0] i_x,
  output logic              o_zero,
  output logic              o_inf,
  output logic              o_nan
);
  logic w_exp_max, w_frac_nz;
  assign w_exp_max = &i_x[DATA_W-2 -: EXP_W];
  assign w_frac_nz = |i_x[DATA_W-EXP_W-2:0];
  assign o_zero    = ~|i_x[DATA_W-2 -: EXP_W];
  assign o_inf     = w_exp_max & ~w_frac_nz;
  assign o_nan     = w_exp_max & w_frac_nz;
endmodule

// File: rtl/mul_addshift.sv
// mul_addshift: unsigned W x W shift-add multiplier, one partial product per enabled cycle.
module mul_addshift #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_en,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p,
  output logic           o_done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  r_mcand, r_hi, r_lo;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [W:0]    w_sum;
  // multiplier bits retire from the low half as product bits shift in from the top
  assign w_sum = {1'b0, r_hi} + {1'b0, {W{r_lo[0]}} & r_mcand};
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_en && !r_done) begin
      {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
      r_cnt        <= r_cnt + CW'(1);
      r_done       <= r_cnt == CW'(W - 1);
    end
  end
  assign o_p    = {r_hi, r_lo};
  assign o_done = r_done;
endmodule

// File: rtl/fp_mul.sv
// fp_mul: iterative IEEE-754 multiplier with fixed MAN_W+3 cycle latency,
// round to nearest even, flush-to-zero underflow.
module fp_mul
  import fp_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              exception
);
  localparam int MAN_W = DATA_W - EXP_W;
  localparam int EXTRA = 3;
  localparam int EW    = EXP_W + 2;
  localparam logic [EW-1:0]        BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EMIN = '0;
  state_e                   r_state;
  spec_e                    r_spec, w_spec;
  logic                     r_sign, r_done, r_ovf, r_unf, r_exc;
  logic [EXP_W-1:0]         r_ea, r_eb;
  logic signed [EW-1:0]     r_e, w_e_n, w_e_r;
  logic [MAN_W+EXTRA-1:0]   r_nm;
  logic [DATA_W-1:0]        r_res, w_res;
  logic [2*MAN_W-1:0]       w_p, w_norm;
  logic [MAN_W-1:0]         w_mant;
  logic [MAN_W:0]           w_sum;
  logic [MAN_W-2:0]         w_man_r;
  logic w_mul_done, w_az, w_ai, w_an, w_bz, w_bi, w_bn, w_up, w_ovf, w_unf;
  fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_a (
    .i_x(op_a[DATA_W-2:0]), .o_zero(w_az), .o_inf(w_ai), .o_nan(w_an));
  fp_special #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_spec_b (
    .i_x(op_b[DATA_W-2:0]), .o_zero(w_bz), .o_inf(w_bi), .o_nan(w_bn));
  mul_addshift #(.W(MAN_W)) u_core (
    .clk(clk), .rst(rst), .i_load(start), .i_en(r_state == MUL),
    .i_a({1'b1, op_a[MAN_W-2:0]}), .i_b({1'b1, op_b[MAN_W-2:0]}),
    .o_p(w_p), .o_done(w_mul_done));
  assign w_spec  = classify(w_az, w_ai, w_an, w_bz, w_bi, w_bn);
  assign w_norm  = w_p[2*MAN_W-1] ? w_p : {w_p[2*MAN_W-2:0], 1'b0};
  assign w_e_n   = EW'(r_ea) + EW'(r_eb) - BIAS + EW'(w_p[2*MAN_W-1]);
  // r_nm = {mantissa, guard, round, sticky}
  assign w_mant  = r_nm[MAN_W+EXTRA-1:EXTRA];
  assign w_up    = r_nm[2] & (r_nm[1] | r_nm[0] | w_mant[0]);
  assign w_sum   = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_up};
  assign w_e_r   = r_e + EW'(w_sum[MAN_W]);
  assign w_man_r = w_sum[MAN_W] ? w_sum[MAN_W-1:1] : w_sum[MAN_W-2:0];
  assign w_ovf   = w_e_r >= EMAX;
  assign w_unf   = w_e_r <= EMIN;
  assign w_res   = r_spec == SP_NAN  ? `NAN :
                   r_spec == SP_INF  ? `INF(r_sign) :
                   r_spec == SP_ZERO ? {r_sign, {(DATA_W-1){1'b0}}} :
                   w_ovf             ? `INF(r_sign) :
                   w_unf             ? {r_sign, {(DATA_W-1){1'b0}}} :
                   {r_sign, w_e_r[EXP_W-1:0], w_man_r};
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state <= MUL;
        r_sign  <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
        r_ea    <= op_a[DATA_W-2 -: EXP_W];
        r_eb    <= op_b[DATA_W-2 -: EXP_W];
        r_spec  <= w_spec;
      end else begin
        case (r_state)
          MUL: if (w_mul_done) r_state <= NORM;
          NORM: begin
            r_e     <= w_e_n;
            r_nm    <= {w_norm[2*MAN_W-1 -: MAN_W+2], |w_norm[MAN_W-3:0]};
            r_state <= RND;
          end
          RND: begin
            r_res   <= w_res;
            r_ovf   <= (r_spec == SP_NONE) & w_ovf;
            r_unf   <= (r_spec == SP_NONE) & ~w_ovf & w_unf;
            r_exc   <= r_spec == SP_NAN;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign done      = r_done;
  assign res       = r_res;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign exception = r_exc;
endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: directed and randomized checks of fp_mul against an arithmetic reference model.
module tb_fp_mul;
  localparam int LAT = 27;
  logic clk, rst, start, done, overflow, underflow, exception;
  logic [31:0] op_a, op_b, res;
  int checks = 0, errors = 0;

  fp_mul #(.DATA_W(32), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .done(done), .res(res), .overflow(overflow), .underflow(underflow), .exception(exception));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {exception, overflow, underflow, result}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s, an, ai, az, bn, bi, bz;
    int ea, eb, e, sh;
    longint ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = ea == 0;
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = eb == 0;
    if (an || bn || (ai && bz) || (bi && az)) return {3'b100, 32'h7FC00000};
    if (ai || bi) return {3'b000, s, 8'hFF, 23'h0};
    if (az || bz) return {3'b000, s, 31'h0};
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + (sh - 23);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int k;
    logic [31:0] x;
    k = $urandom_range(0, 19);
    x = $urandom;
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) x[30:23] = 8'hFF;
    else if (k == 2) x = {x[31], 8'hFF, 23'h0};
    else if (k < 12) x[30:23] = 8'($urandom_range(100, 154));
    return x;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 00000000", res); end
    checks++; if ({exception, overflow, underflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {exception, overflow, underflow}); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] va[8], vb[8], vr[8];
    logic [2:0]  vf[8];
    int lat;
    va = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h7F000000,
           32'h00800000, 32'h7F800000, 32'hFF800000, 32'hC0000000};
    vb = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h40000000,
           32'h00800000, 32'h00000000, 32'h40000000, 32'h00000000};
    vr = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h7F800000,
           32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    vf = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i]);
      wait_done(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL dir%0d_res: got %h want %h", i, res, vr[i]); end
      checks++; if ({exception, overflow, underflow} !== vf[i]) begin
        errors++; $display("FAIL dir%0d_flags: got %b want %b", i, {exception, overflow, underflow}, vf[i]); end
    end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [34:0] e;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_fp();
      b = rand_fp();
      e = model(a, b);
      issue(a, b);
      wait_done(lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (res !== e[31:0]) begin
        errors++; $display("FAIL rnd%0d_res: a=%h b=%h got %h want %h", i, a, b, res, e[31:0]); end
      checks++; if ({exception, overflow, underflow} !== e[34:32]) begin
        errors++; $display("FAIL rnd%0d_flags: a=%h b=%h got %b want %b", i, a, b,
                           {exception, overflow, underflow}, e[34:32]); end
    end
  endtask

  task automatic test_hold();
    logic [34:0] e;
    int lat;
    e = model(32'h40490FDB, 32'hC02DF854);
    issue(32'h40490FDB, 32'hC02DF854);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      op_a = $urandom;
      op_b = $urandom;
      @(posedge clk);
      #1;
    end
    checks++; if (res !== e[31:0]) begin errors++; $display("FAIL hold_res: got %h want %h", res, e[31:0]); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] e;
    int n, at;
    e  = model(32'h40A00000, 32'h40E00000);
    n  = 0;
    at = -1;
    issue(32'h3FC00000, 32'h40000000);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    issue(32'h40A00000, 32'h40E00000);
    for (int k = 6; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n++;
        at = k;
      end
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL restart_count: got %0d want 1", n); end
    checks++; if (at !== 32) begin errors++; $display("FAIL restart_edge: got %0d want 32", at); end
    checks++; if (res !== e[31:0]) begin errors++; $display("FAIL restart_res: got %h want %h", res, e[31:0]); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] e;
    int n, lat;
    n = 0;
    issue(32'h3FC00000, 32'h40000000);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL midrst_res: got %h want 00000000", res); end
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_done_count: got %0d want 0", n); end
    e = model(32'hC1200000, 32'h3E800000);
    issue(32'hC1200000, 32'h3E800000);
    wait_done(lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL postrst_latency: got %0d want %0d", lat, LAT); end
    checks++; if (res !== e[31:0]) begin errors++; $display("FAIL postrst_res: got %h want %h", res, e[31:0]); end
  endtask

  task automatic test_rst_priority();
    int n;
    n = 0;
    rst = 1'b0;
    issue(32'h40000000, 32'h40000000);
    rst = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL rst_priority_done_count: got %0d want 0", n); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rst_priority_res: got %h want 00000000", res); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_rst_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
